// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write-to-read bypass,
// a per-register pending scoreboard and a registered debug read port.
module regfile_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NRD*AW-1:0] read_reg,
   output logic [NRD*XLEN-1:0] read_data,
   output logic [NRD-1:0]    read_pending,
   input  logic              write_en,
   input  logic [AW-1:0]     write_reg,
   input  logic [XLEN-1:0]   write_data,
   input  logic              issue_en,
   input  logic [AW-1:0]     issue_reg,
   input  logic [AW-1:0]     dbg_reg,
   output logic [XLEN-1:0]   dbg_data,
   output logic [15:0]       wr_count
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] pend_q, pend_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]  dbg_q, dbg_d;
   logic             wr_valid;

   assign wr_valid = write_en && (write_reg != '0);

   // Issue is applied after the write clear so a same-cycle issue keeps the register pending.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (wr_valid) begin
         regs_d[write_reg] = write_data;
         pend_d[write_reg] = 1'b0;
         cnt_d             = cnt_q + 16'd1;
      end
      if (issue_en && (issue_reg != '0)) begin
         pend_d[issue_reg] = 1'b1;
      end
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
   end

   always_comb begin
      dbg_d = '0;
      if (dbg_reg == '0) begin
         dbg_d = '0;
      end else if (wr_valid && (write_reg == dbg_reg)) begin
         dbg_d = write_data;
      end else begin
         dbg_d = regs_q[dbg_reg];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         pend_q <= '0;
         cnt_q  <= '0;
         dbg_q  <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         dbg_q  <= dbg_d;
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;
      assign addr = read_reg[g*AW +: AW];
      assign hit  = wr_valid && (write_reg == addr);
      assign read_data[g*XLEN +: XLEN] = (addr == '0) ? '0 :
                                         hit          ? write_data : regs_q[addr];
      assign read_pending[g] = pend_q[addr] & ~hit;
   end

   assign dbg_data = dbg_q;
   assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, reset and wrap
// sequences, and randomized traffic against a behavioural register-file model.
module tb_regfile_mp;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 3;
   localparam int AW    = 5;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [NRD*AW-1:0]    read_reg;
   logic [NRD*XLEN-1:0]  read_data;
   logic [NRD-1:0]       read_pending;
   logic                 write_en;
   logic [AW-1:0]        write_reg;
   logic [XLEN-1:0]      write_data;
   logic                 issue_en;
   logic [AW-1:0]        issue_reg;
   logic [AW-1:0]        dbg_reg;
   logic [XLEN-1:0]      dbg_data;
   logic [15:0]          wr_count;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk(clk), .rstn(rstn), .read_reg(read_reg), .read_data(read_data),
      .read_pending(read_pending), .write_en(write_en), .write_reg(write_reg),
      .write_data(write_data), .issue_en(issue_en), .issue_reg(issue_reg),
      .dbg_reg(dbg_reg), .dbg_data(dbg_data), .wr_count(wr_count)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] m_regs [NREGS];
   logic        m_pend [NREGS];
   logic [15:0] m_cnt;
   logic [31:0] m_dbg;

   typedef struct {
      logic        we; logic [4:0] wr; logic [31:0] wd;
      logic        ie; logic [4:0] ir;
      logic [4:0]  r0, r1, r2, dbg;
      logic [31:0] e0, e1, e2;
      logic [2:0]  ep;
      logic [31:0] edbg;
      logic [15:0] ecnt;
   } vec_t;
   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (write_en && write_reg == a) return write_data;
      return m_regs[a];
   endfunction

   function automatic logic model_pending(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (write_en && write_reg == a) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = 32'h0;
         m_pend[i] = 1'b0;
      end
      m_cnt = 16'h0;
      m_dbg = 32'h0;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      if (rstn) begin
         m_dbg = model_read(dbg_reg);
         if (write_en && write_reg != 5'd0) begin
            m_regs[write_reg] = write_data;
            m_pend[write_reg] = 1'b0;
            m_cnt = m_cnt + 16'd1;
         end
         if (issue_en && issue_reg != 5'd0) m_pend[issue_reg] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ir,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] dr);
      write_en   = we;
      write_reg  = wr;
      write_data = wd;
      issue_en   = ie;
      issue_reg  = ir;
      read_reg   = {r2, r1, r0};
      dbg_reg    = dr;
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic [4:0] a;
      for (int p = 0; p < NRD; p++) begin
         a = read_reg[p*AW +: AW];
         check($sformatf("%s rd%0d", tag, p), read_data[p*XLEN +: XLEN], model_read(a));
         check($sformatf("%s pend%0d", tag, p), {31'h0, read_pending[p]}, {31'h0, model_pending(a)});
      end
      check({tag, " dbg"}, dbg_data, m_dbg);
      check({tag, " cnt"}, {16'h0, wr_count}, {16'h0, m_cnt});
   endtask

   initial begin
      tbl[0]  = '{1'b1, 5'd5,  32'hA5A5A5A5, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0,
                  32'hA5A5A5A5, 32'h0, 32'h0, 3'b000, 32'h0, 16'd0};
      tbl[1]  = '{1'b1, 5'd6,  32'h5A5A5A5A, 1'b0, 5'd0, 5'd5, 5'd6, 5'd5, 5'd0,
                  32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 3'b000, 32'h0, 16'd1};
      tbl[2]  = '{1'b1, 5'd11, 32'h12345678, 1'b0, 5'd0, 5'd11, 5'd6, 5'd5, 5'd0,
                  32'h12345678, 32'h5A5A5A5A, 32'hA5A5A5A5, 3'b000, 32'h0, 16'd2};
      tbl[3]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd7, 5'd7, 5'd5, 5'd6, 5'd6,
                  32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b000, 32'h0, 16'd3};
      tbl[4]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 5'd11, 5'd6,
                  32'h0, 32'h0, 32'h12345678, 3'b011, 32'h5A5A5A5A, 16'd3};
      tbl[5]  = '{1'b1, 5'd7,  32'h42, 1'b0, 5'd0, 5'd7, 5'd0, 5'd7, 5'd6,
                  32'h42, 32'h0, 32'h42, 3'b000, 32'h5A5A5A5A, 16'd3};
      tbl[6]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd6,
                  32'h42, 32'h0, 32'h0, 3'b000, 32'h5A5A5A5A, 16'd4};
      tbl[7]  = '{1'b1, 5'd7,  32'h99, 1'b1, 5'd7, 5'd7, 5'd0, 5'd0, 5'd6,
                  32'h99, 32'h0, 32'h0, 3'b000, 32'h5A5A5A5A, 16'd4};
      tbl[8]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7, 5'd6,
                  32'h99, 32'h99, 32'h99, 3'b111, 32'h5A5A5A5A, 16'd5};
      tbl[9]  = '{1'b1, 5'd6,  32'h0BADF00D, 1'b0, 5'd0, 5'd6, 5'd0, 5'd0, 5'd6,
                  32'h0BADF00D, 32'h0, 32'h0, 3'b000, 32'h5A5A5A5A, 16'd5};
      tbl[10] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 5'd6, 5'd7, 5'd0, 5'd6,
                  32'h0BADF00D, 32'h99, 32'h0, 3'b010, 32'h0BADF00D, 16'd6};
      tbl[11] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd6,
                  32'h0, 32'h0, 32'h0, 3'b000, 32'h0BADF00D, 16'd6};
      tbl[12] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 5'd11, 5'd6,
                  32'h0, 32'hA5A5A5A5, 32'h12345678, 3'b000, 32'h0BADF00D, 16'd6};

      // Reset held while a write is driven: nothing may be committed.
      rstn = 1'b0;
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd6, 5'd6, 5'd6, 5'd5);
      repeat (3) @(posedge clk);
      #1;
      check("reset rd_other", read_data[31:0], 32'h0);
      check("reset pend", {29'h0, read_pending}, 32'h0);
      check("reset dbg", dbg_data, 32'h0);
      check("reset cnt", {16'h0, wr_count}, 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 5'd5);
      rstn = 1'b1;
      model_reset();
      tick();
      check("post-reset rd5", read_data[31:0], 32'h0);
      check("post-reset cnt", {16'h0, wr_count}, 32'h0);
      check("post-reset dbg", dbg_data, 32'h0);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].ie, tbl[i].ir,
                       tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].dbg);
         check($sformatf("vec%0d rd0", i), read_data[31:0], tbl[i].e0);
         check($sformatf("vec%0d rd1", i), read_data[63:32], tbl[i].e1);
         check($sformatf("vec%0d rd2", i), read_data[95:64], tbl[i].e2);
         check($sformatf("vec%0d pend", i), {29'h0, read_pending}, {29'h0, tbl[i].ep});
         check($sformatf("vec%0d dbg", i), dbg_data, tbl[i].edbg);
         check($sformatf("vec%0d cnt", i), {16'h0, wr_count}, {16'h0, tbl[i].ecnt});
         tick();
      end

      // Asynchronous reset pulsed between edges clears everything at once.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd5, 5'd7, 5'd6, 5'd6);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd3, 5'd6, 5'd6);
      rstn = 1'b0;
      #1;
      check("async rd0", read_data[31:0], 32'h0);
      check("async rd1", read_data[63:32], 32'h0);
      check("async rd2", read_data[95:64], 32'h0);
      check("async pend", {29'h0, read_pending}, 32'h0);
      check("async dbg", dbg_data, 32'h0);
      check("async cnt", {16'h0, wr_count}, 32'h0);
      #1;
      rstn = 1'b1;
      model_reset();
      tick();

      // Randomized traffic on a narrow address range to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         checkOutput($sformatf("rand%0d", n));
         tick();
      end

      // Counter wrap: 65537 counted writes to x1, with uncounted x0 writes mixed in.
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      model_reset();
      for (int n = 0; n < 65537; n++) begin
         if (n % 4096 == 0) begin
            applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd1, 5'd0, 5'd1, 5'd1);
            tick();
         end
         applyStimulus(1'b1, 5'd1, 32'(n), 1'b0, 5'd0, 5'd1, 5'd0, 5'd1, 5'd1);
         tick();
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd0, 5'd2, 5'd1);
      check("wrap cnt", {16'h0, wr_count}, 32'd1);
      check("wrap rd1", read_data[31:0], 32'd65536);
      checkOutput("wrap");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the pipelined RV32 core. It replaces the fixed two-read-port regfile and adds three things: same-cycle write-to-read bypass, a per-register pending scoreboard for decode-stage hazard detection, and a registered debug read port. It sits between decode (reads, issue marks) and writeback (write port).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two ≥ 2; AW = log2(NREGS)
- NRD, 2, number of read ports, 1..4

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- read_reg  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- read_data  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
- read_pending  out  NRD  port i's register has an outstanding producer
- write_en  in  1  writeback enable
- write_reg  in  AW  writeback address
- write_data  in  XLEN  writeback data
- issue_en  in  1  decode issues an instruction that will write issue_reg
- issue_reg  in  AW  destination of the issued instruction
- dbg_reg  in  AW  debug read address
- dbg_data  out  XLEN  registered debug data
- wr_count  out  16  count of committed non-x0 writes; wraps

## Operation
- Storage: NREGS x XLEN flops. Register 0 reads as 0 and is never written or marked pending.
- Write: at a rising edge with write_en=1 and write_reg≠0, regs[write_reg] ← write_data. At the same edge, pend[write_reg] ← 0 and wr_count ← wr_count+1 (modulo 2^16). A write to x0 has no effect on any state.
- Read port i is combinational:
  - read_reg=0 → read_data=0.
  - Otherwise, write_en=1 and write_reg=read_reg → read_data=write_data (bypass).
  - Otherwise → read_data=regs[read_reg].
- All NRD ports are independent. Any number of ports may address the same register.
- read_pending[i] = pend[read_reg_i] AND NOT (write_en AND write_reg=read_reg_i AND read_reg_i≠0). It is 0 for x0.
- Issue: at a rising edge with issue_en=1 and issue_reg≠0, pend[issue_reg] ← 1.
- Simultaneous issue and write to the same register in one cycle:
  - The register data updates.
  - Issue wins, so pend stays or becomes 1 (a new producer is in flight).
  - read_pending in that cycle still shows 0 through the bypass rule; the 1 appears next cycle.
- Debug: at each rising edge, dbg_data ← value the read-port rule would give for dbg_reg, including the bypass. dbg_data is for observation only and does not affect other state.

## Timing
- Reset (rstn=0, asynchronous, immediate): all regs=0, all pend=0, dbg_data=0, wr_count=0. As a result, read_data=0 and read_pending=0 for every port while reset is held, apart from any combinational bypass of write_data.
- Reset deasserts synchronously in effect: the first edge with rstn=1 is the first one that updates state.
- Reset asserted mid-operation discards any in-flight write or issue in that cycle.
- Read latency: 0 cycles (combinational). Write visible through read_data in the same cycle via bypass, and from regs on the next cycle.
- Scoreboard: set/clear take effect at the edge and are visible on read_pending from the next cycle.
- dbg_data latency: 1 cycle.
- No handshakes and no backpressure: every enabled write or issue is accepted every cycle.

## Test plan
- Reset and x0:
  - Hold rstn=0 and drive write_en=1, write_reg=5, write_data=32'hDEADBEEF; release reset → reading 5 returns 0 and wr_count=0.
  - Write 32'hFFFFFFFF to x0 → port reads 0, wr_count unchanged.
- Write/read plus bypass (NRD=3):
  - Write reg5=32'hA5A5A5A5, then reg6=32'h5A5A5A5A.
  - Ports read 5, 6, 5 → A5A5A5A5, 5A5A5A5A, A5A5A5A5.
  - In the same cycle, write reg11=32'h12345678 while port0 reads 11 → read_data0=12345678 before the edge.
- Scoreboard:
  - Issue reg7 → read_pending=1 from the next cycle.
  - Write reg7=32'h00000042 → pending drops in the write cycle through the bypass; reads 42 afterwards.
  - Issue and write reg7 in the same cycle → pending=1 the following cycle.
- Debug port: dbg_reg=6 → dbg_data=5A5A5A5A one cycle later. Writing reg6=32'h0BADF00D while dbg_reg=6 → dbg_data=0BADF00D at the next edge.
- Async reset mid-run: after the writes and issues above, pulse rstn low between edges → all read_data, read_pending, dbg_data and wr_count are 0 immediately.
- wr_count wrap: 65537 writes to reg1 → wr_count=1. Writes to x0 interleaved with them are not counted.
